// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl
//   Sequences exception, interrupt and ERET commit between the M stage and
//   CP0. One event is captured per sequence, committed to CP0 with a single
//   cycle strobe, followed by a fixed-length pipeline flush and a PC
//   redirect that is held until fetch accepts it.
//
//   Sequence: IDLE -> COMMIT (1 cycle) -> FLUSH (FLUSH_CYCLES cycles)
//             -> REDIRECT (until redirect_ready) -> IDLE
//
//   Parameters:
//     EXC_VECTOR    exception / interrupt entry PC
//     FLUSH_CYCLES  cycles spent in FLUSH (1..15); flush is high for
//                   FLUSH_CYCLES+1 cycles counting COMMIT
//
//   Ports:
//     clk, reset                  clock, synchronous active-high reset
//     m_valid .. m_is_mtc0        M-stage instruction information
//     status, cause, epc          CP0 state used for event selection / ERET
//     redirect_ready              fetch accepts the redirect
//     cmt_*                       commit record to CP0 (strobe = cmt_valid)
//     flush, stall                pipeline kill / freeze
//     redirect_valid/pc           PC redirect to fetch
//     busy                        sequence in progress (not IDLE)
//
//   Optional build macro EXC_CTRL_PERF_EN adds perf_exc_cnt, perf_int_cnt
//   and perf_eret_cnt: wrapping 32-bit counts of committed events by type.
module exc_commit_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_is_exc,
  input  logic [4:0]  m_exc_code,
  input  logic [31:0] m_badvaddr,
  input  logic        m_is_in_ds,
  input  logic        m_is_eret,
  input  logic        m_is_mtc0,
  input  logic [31:0] status,
  input  logic [31:0] cause,
  input  logic [31:0] epc,
  input  logic        redirect_ready,
  output logic        cmt_valid,
  output logic [31:0] cmt_pc,
  output logic [4:0]  cmt_exc_code,
  output logic [31:0] cmt_badvaddr,
  output logic        cmt_bd,
  output logic        cmt_is_eret,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
`ifdef EXC_CTRL_PERF_EN
  ,
  output logic [31:0] perf_exc_cnt,
  output logic [31:0] perf_int_cnt,
  output logic [31:0] perf_eret_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, COMMIT, FLUSH, REDIRECT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] target_reg;

  logic int_pending;
  logic take_exc;
  logic take_eret;
  logic take_int;
  logic capture;

  assign int_pending = status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));

  // Priority: exception > ERET > interrupt. Interrupts wait out an MTC0 so
  // that a Status/Cause write has settled before it can be taken.
  assign take_exc  = m_valid & m_is_exc;
  assign take_eret = m_valid & ~m_is_exc & m_is_eret;
  assign take_int  = m_valid & ~m_is_exc & ~m_is_eret & int_pending & ~m_is_mtc0;
  assign capture   = (state_reg == IDLE) & (take_exc | take_eret | take_int);

  // Only the IE/EXL/IM fields of Status and the IP field of Cause matter.
  logic unused_bits;
  assign unused_bits = ^{status[31:16], status[7:2], cause[31:16], cause[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      target_reg     <= 32'd0;
      cmt_valid      <= 1'b0;
      cmt_pc         <= 32'd0;
      cmt_exc_code   <= 5'd0;
      cmt_badvaddr   <= 32'd0;
      cmt_bd         <= 1'b0;
      cmt_is_eret    <= 1'b0;
      flush          <= 1'b0;
      stall          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      busy           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (capture) begin
            state_reg   <= COMMIT;
            cmt_valid   <= 1'b1;
            flush       <= 1'b1;
            stall       <= 1'b1;
            busy        <= 1'b1;
            cmt_is_eret <= take_eret;
            // An interrupted delay-slot instruction restarts at its branch.
            cmt_pc      <= (take_int & m_is_in_ds) ? (m_pc - 32'd4) : m_pc;
            target_reg  <= take_eret ? epc : EXC_VECTOR;
            if (take_exc) begin
              cmt_exc_code <= m_exc_code;
              cmt_badvaddr <= m_badvaddr;
              cmt_bd       <= m_is_in_ds;
            end
            if (take_int) begin
              cmt_exc_code <= 5'd0;
              cmt_bd       <= m_is_in_ds;
            end
          end
        end
        COMMIT: begin
          cmt_valid <= 1'b0;
          cnt_reg   <= CNT_INIT;
          state_reg <= FLUSH;
        end
        FLUSH: begin
          if (cnt_reg == 4'd0) begin
            state_reg      <= REDIRECT;
            flush          <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= target_reg;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state_reg      <= IDLE;
            redirect_valid <= 1'b0;
            stall          <= 1'b0;
            busy           <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef EXC_CTRL_PERF_EN
  // Event type of the captured commit: 0 = exception, 1 = interrupt, 2 = ERET.
  logic [1:0] kind_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      kind_reg      <= 2'd0;
      perf_exc_cnt  <= 32'd0;
      perf_int_cnt  <= 32'd0;
      perf_eret_cnt <= 32'd0;
    end else begin
      if (capture) begin
        kind_reg <= take_exc ? 2'd0 : (take_int ? 2'd1 : 2'd2);
      end
      if (cmt_valid) begin
        case (kind_reg)
          2'd0:    perf_exc_cnt  <= perf_exc_cnt + 32'd1;
          2'd1:    perf_int_cnt  <= perf_int_cnt + 32'd1;
          default: perf_eret_cnt <= perf_eret_cnt + 32'd1;
        endcase
      end
    end
  end
`endif

endmodule
